// File: rtl/alu_operand_b_stage_if.sv
// alu_operand_b_stage_if
//  Request and response bundle for the ALU source-B operand stage.
//  Request side : in_data_i, sel_i, mode_i, in_valid_i  -> stage
//                 in_ready_o                             <- stage
//  Response side: out_data_o, out_valid_o                <- stage
//                 out_ready_i                            -> stage
//  slave  modport: the operand stage itself.
//  master modport: whoever issues requests and consumes operands.
interface alu_operand_b_stage_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3
) ();
  logic [NUM_IN*WIDTH-1:0] in_data_i;
  logic [SEL_W-1:0]        sel_i;
  logic [1:0]              mode_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [WIDTH-1:0]        out_data_o;
  logic                    out_valid_o;
  logic                    out_ready_i;

  modport slave (
    input  in_data_i, sel_i, mode_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o
  );

  modport master (
    output in_data_i, sel_i, mode_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o
  );
endinterface

// File: rtl/alu_operand_b_stage.sv
// alu_operand_b_stage
//  Registered ALU source-B select. Picks one of NUM_IN packed operands or the
//  increment constant, applies an immediate-extension mode, and buffers the
//  result in a 2-entry valid/ready queue. Illegal selects raise a sticky
//  error flag and bump a saturating 8-bit counter.
//  Ports:
//    clk         rising-edge clock
//    reset_n     asynchronous active-low reset
//    bus         request/response bundle (slave side)
//    flush_i     empties the queue at the next edge
//    clr_err_i   clears err_o at the next edge
//    err_o       sticky illegal-select flag
//    err_cnt_o   saturating count of accepted illegal selects
module alu_operand_b_stage #(
  parameter int          WIDTH     = 32,
  parameter int          NUM_IN    = 5,
  parameter int          SEL_W     = 3,
  parameter int          IMM_W     = 16,
  parameter int unsigned CONST_INC = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  alu_operand_b_stage_if.slave  bus,
  input  logic                  flush_i,
  input  logic                  clr_err_i,
  output logic                  err_o,
  output logic [7:0]            err_cnt_o
);

  logic [WIDTH-1:0] src [NUM_IN];
  logic [WIDTH-1:0] picked;
  logic [IMM_W-1:0] imm;
  logic [WIDTH-1:0] sext_val;
  logic [WIDTH-1:0] result;
  logic             sel_illegal;

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic push, pop, illegal_push;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_src
      assign src[gi] = bus.in_data_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Select decode and immediate extension, evaluated on the request inputs
  // so the result is ready to be captured on the push edge.
  always_comb begin
    picked = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel_i == SEL_W'(k)) picked = src[k];
    end
    imm      = picked[IMM_W-1:0];
    sext_val = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    sel_illegal = (bus.sel_i > SEL_W'(NUM_IN));

    if (bus.sel_i == SEL_W'(NUM_IN)) begin
      result = WIDTH'(CONST_INC);
    end else if (sel_illegal) begin
      result = '0;
    end else begin
      case (bus.mode_i)
        2'b00:   result = picked;
        2'b01:   result = sext_val;
        2'b10:   result = {{(WIDTH-IMM_W){1'b0}}, imm};
        default: result = sext_val << 2;
      endcase
    end
  end

  // in_ready depends only on registered occupancy (and reset), never on out_ready.
  assign bus.in_ready_o  = reset_n & (count_q != 2'd2);
  assign bus.out_valid_o = (count_q != 2'd0);
  assign bus.out_data_o  = head_q;
  assign err_o           = err_q;
  assign err_cnt_o       = err_cnt_q;

  assign push         = bus.in_valid_i & bus.in_ready_o;
  assign pop          = bus.out_valid_o & bus.out_ready_i;
  // A push discarded by flush still reports its illegal select.
  assign illegal_push = push & sel_illegal;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = result;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = result;          // old head leaves, new entry takes its place
          end else if (push) begin
            tail_d  = result;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
      endcase
    end

    err_d = err_q;
    if (illegal_push)   err_d = 1'b1;   // new event beats a simultaneous clear
    else if (clr_err_i) err_d = 1'b0;

    err_cnt_d = err_cnt_q;
    if (illegal_push && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_b_stage.sv
module tb_alu_operand_b_stage;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 5;
  localparam int SEL_W  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic flush = 1'b0;
  logic clr = 1'b0;
  logic err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  alu_operand_b_stage_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

  alu_operand_b_stage #(
    .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .IMM_W(16), .CONST_INC(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .flush_i   (flush),
    .clr_err_i (clr),
    .err_o     (err),
    .err_cnt_o (err_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;
  int n_push = 0;

  // Reference state: queue contents, sticky flag, event counter.
  logic [31:0] mq[$];
  bit          m_err = 1'b0;
  int          m_cnt = 0;
  logic [31:0] popped[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand value from the select/mode rules, using signed integer arithmetic.
  function automatic logic [31:0] model_val(logic [NUM_IN*WIDTH-1:0] d, int sel, int mode);
    logic [31:0] src;
    longint lo, sx;
    if (sel == NUM_IN) return 32'd4;
    if (sel > NUM_IN) return 32'd0;
    src = d[sel*WIDTH +: WIDTH];
    lo = longint'(src[15:0]);
    sx = (lo >= 32768) ? lo - 65536 : lo;
    case (mode)
      0:       return src;
      1:       return 32'(sx);
      2:       return 32'(lo);
      default: return 32'(sx * 4);
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      bit do_push, do_pop, ill;
      logic [31:0] v;
      do_push = bus.in_valid_i && (mq.size() < 2);
      do_pop  = (mq.size() != 0) && bus.out_ready_i;
      ill     = do_push && (int'(bus.sel_i) > NUM_IN);
      v = model_val(bus.in_data_i, int'(bus.sel_i), int'(bus.mode_i));
      if (do_push) begin
        n_push++;
        $display("push %0d: sel=%0d mode=%0d flush=%0b -> %h", n_push, bus.sel_i, bus.mode_i, flush, v);
      end
      if (flush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(v);
      end
      if (ill) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      if (ill && m_cnt < 255) m_cnt++;
    end
  end

  // Per-cycle compare against the reference.
  always @(negedge clk) begin
    chk("in_ready", 32'(bus.in_ready_o), 32'(reset_n && (mq.size() < 2)));
    chk("out_valid", 32'(bus.out_valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_data", bus.out_data_o, mq[0]);
    chk("err", 32'(err), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    if (reset_n && bus.out_valid_o && bus.out_ready_i) popped.push_back(bus.out_data_o);
  end

  task automatic set_req(bit v, int s, int m);
    bus.in_valid_i = v;
    bus.sel_i      = SEL_W'(s);
    bus.mode_i     = 2'(m);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          dsel [6] = '{0, 5, 1, 1, 1, 5};
  int          dmode[6] = '{0, 0, 1, 2, 3, 3};
  logic [31:0] dexp [6] = '{32'hDEADBEEF, 32'h00000004, 32'hFFFF8001,
                            32'h00008001, 32'hFFFE0004, 32'h00000004};
  logic [31:0] bpv[3] = '{32'h11110001, 32'h22220002, 32'h33330003};
  logic [31:0] pv[11];

  initial begin
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;
    set_req(0, 0, 0);

    // Reset state
    #1 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_out_data", bus.out_data_o, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (3) step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready_o), 32'd1);

    // Decode table
    bus.in_data_i[0 +: 32]  = 32'hDEADBEEF;
    bus.in_data_i[32 +: 32] = 32'h12348001;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      set_req(1, dsel[i], dmode[i]);
      step();
      set_req(0, 0, 0);
      @(negedge clk);
      chk("decode_dut", bus.out_data_o, dexp[i]);
      chk("decode_model", model_val(bus.in_data_i, dsel[i], dmode[i]), dexp[i]);
    end

    // Backpressure: third request stalls, then everything drains in order
    step();
    bus.out_ready_i = 1'b0;
    popped.delete();
    bus.in_data_i[0 +: 32] = bpv[0];
    set_req(1, 0, 0);
    step();
    bus.in_data_i[0 +: 32] = bpv[1];
    step();
    bus.in_data_i[0 +: 32] = bpv[2];
    @(negedge clk);
    chk("bp_stall_ready", 32'(bus.in_ready_o), 32'd0);
    step();
    step();
    bus.out_ready_i = 1'b1;
    step();
    step();
    set_req(0, 0, 0);
    repeat (2) step();
    @(negedge clk);
    #1;
    chk("bp_count", 32'(popped.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("bp_order", (i < popped.size()) ? popped[i] : 32'hX, bpv[i]);

    // Simultaneous push/pop at occupancy 1
    popped.delete();
    for (int i = 0; i < 11; i++) pv[i] = $urandom();
    for (int i = 0; i < 11; i++) begin
      bus.in_data_i[0 +: 32] = pv[i];
      set_req(1, 0, 0);
      @(negedge clk);
      chk("pp_head", bus.out_data_o, pv[i]);
      chk("pp_in_ready", 32'(bus.in_ready_o), 32'd1);
    end
    set_req(0, 0, 0);
    @(negedge clk);
    #1;
    chk("pp_count", 32'(popped.size()), 32'd11);
    for (int i = 0; i < 11; i++) chk("pp_once", (i < popped.size()) ? popped[i] : 32'hX, pv[i]);

    // Errors: three illegal pushes with a clear on the second
    set_req(1, 7, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    set_req(0, 0, 0);
    chk("err_after3", 32'(err), 32'd1);
    chk("cnt_after3", 32'(err_cnt), 32'd3);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    chk("cnt_keep", 32'(err_cnt), 32'd3);
    set_req(1, 7, 2);
    repeat (300) @(negedge clk);
    set_req(0, 0, 0);
    chk("cnt_sat", 32'(err_cnt), 32'd255);

    // Asynchronous reset with a full queue
    bus.out_ready_i = 1'b0;
    bus.in_data_i[0 +: 32] = 32'hA5A5A5A5;
    set_req(1, 0, 0);
    repeat (2) @(negedge clk);
    set_req(0, 0, 0);
    chk("full_in_ready", 32'(bus.in_ready_o), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready_o), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(bus.in_ready_o), 32'd1);

    // Flush at occupancy 2 with a concurrent push
    bus.in_data_i[0 +: 32] = 32'h01010101;
    set_req(1, 0, 0);
    @(negedge clk);
    bus.in_data_i[0 +: 32] = 32'h02020202;
    @(negedge clk);
    flush = 1'b1;
    bus.in_data_i[0 +: 32] = 32'h03030303;
    @(negedge clk);
    flush = 1'b0;
    set_req(0, 0, 0);
    chk("flush_valid", 32'(bus.out_valid_o), 32'd0);
    bus.in_data_i[0 +: 32] = 32'h0BADF00D;
    set_req(1, 0, 0);
    @(negedge clk);
    set_req(0, 0, 0);
    chk("post_flush_data", bus.out_data_o, 32'h0BADF00D);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("post_flush_alone", 32'(bus.out_valid_o), 32'd0);

    // Flush at occupancy 1 with a concurrent illegal push: dropped but counted
    bus.out_ready_i = 1'b0;
    set_req(1, 0, 0);
    @(negedge clk);
    flush = 1'b1;
    set_req(1, 7, 0);
    @(negedge clk);
    flush = 1'b0;
    set_req(0, 0, 0);
    chk("flush_ill_valid", 32'(bus.out_valid_o), 32'd0);
    chk("flush_ill_cnt", 32'(err_cnt), 32'd1);
    chk("flush_ill_err", 32'(err), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      for (int k = 0; k < NUM_IN; k++) bus.in_data_i[k*WIDTH +: WIDTH] = $urandom();
      set_req($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    set_req(0, 0, 0);
    flush = 1'b0;
    clr = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
